mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle MIPS main controller. Sequences one shared ALU, one shared memory port, the register file, the PC and the IR through fetch/decode/execute/memory/writeback states.
- Replaces the single-cycle opcode decoder when the datapath is built multicycle. Adds a memory ready handshake with timeout, illegal-opcode trapping and a retire pulse.
- Sits between the IR opcode field and all datapath mux selects and enables.

Parameters:
- SUPPORT_ADDI, 1, 1 = decode addi (001000); 0 = treat addi as illegal.
- MEM_WAIT_MAX, 15, maximum wait cycles for mem_ready per access before a bus error (range 1..255).
- WAIT_W, 8, width of the wait counter. Must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- op  in  6  IR[31:26], sampled in DECODE.
- mem_ready  in  1  memory completes the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  1 = write MDR to the register file, 0 = write ALUOut.
- reg_dst  out  1  1 = rd, 0 = rt.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = regA.
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct decode.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- retired  out  1  one-cycle pulse on the last cycle of each completed instruction.
- illegal_op  out  1  sticky; set when an undefined opcode is decoded.
- bus_error  out  1  sticky; set on memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Synchronous active-high rst, sampled at clk edge. Next state is FETCH, wait_cnt=0, illegal_op=0, bus_error=0. A reset asserted mid-instruction, including during a memory wait, aborts it with no write issued in the reset cycle.
- Outputs are Moore-decoded from state, except the gated strobes below. All enables and strobes are 0, and all selects are 0, unless listed for the current state.
- State encoding (4 bits):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERROR=15.
- FETCH:
  - mem_read=1, i_or_d=0.
  - When mem_ready=1: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; next DECODE.
  - Otherwise stay in FETCH. ir_write and pc_write are gated by mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by op:
  - 000000 -> EXEC.
  - 100011 and 101011 -> MEMADR.
  - 000100 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> ADDIEX if SUPPORT_ADDI.
  - Any other op -> ERROR and set illegal_op.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEMRD for lw, MEMWR for sw. op is held stable by the IR.
- MEMRD: mem_read=1, i_or_d=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, retired=1; next FETCH.
- MEMWR:
  - mem_write=1, i_or_d=1.
  - On mem_ready: retired=1, next FETCH.
  - mem_write stays high for the whole wait.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, retired=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retired=1; next FETCH.
- JUMP: pc_write=1, pc_source=10, retired=1; next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, retired=1; next FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - If wait_cnt==MEM_WAIT_MAX while mem_ready=0: next ERROR, bus_error=1.
  - If mem_ready=1 in that same cycle, the access completes normally; mem_ready has priority.
- ERROR: all enables 0. Stay in ERROR until rst. Sticky flags are unchanged.
- Latencies with zero wait states: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each memory state adds one cycle per mem_ready=0 cycle.
- No illegal state is reachable. The default branch of the next-state logic goes to ERROR.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - state encodings;
  - alu_op, alu_src_b and pc_source encodings.
- Single module with no sub-module. The next-state and output decode are one combinational block; the state register, wait counter and sticky flags are one sequential block.

Test Plan:
- rst=1 for 2 cycles, then 0 with mem_ready=1: state_dbg=0, all enables 0 during reset; cycle 1 after reset has mem_read=1, ir_write=1, pc_write=1.
- op=000000, mem_ready=1 always: states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. retired pulses once per 4 cycles.
- op=100011, mem_ready low 3 cycles in MEMRD: states 0,1,2,3,3,3,3,4,0. mem_read stays high through the waits; reg_write=1 and mem_to_reg=1 in state 4.
- op=000100 then op=000010: beq gives pc_write_cond=1 and pc_source=01 in state 8. j gives pc_write=1 and pc_source=10 in state 9. Each takes 3 cycles.
- op=111111, then separately mem_ready=0 for 16 cycles in FETCH (MEM_WAIT_MAX=15): first gives illegal_op=1, state 15; second gives bus_error=1, state 15. Both hold until rst returns state 0 with both flags cleared.
- rst asserted in MEMWR during a wait: next cycle state 0, mem_write=0, no retired pulse.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states and
// datapath select values.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_ERROR  = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REGB    = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences the shared ALU, memory port,
// register file, PC and IR, with memory-ready timeout and illegal-op trap.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned SUPPORT_ADDI = 1,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retired,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_wait;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;
    mem_wait      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    retired       = 1'b0;

    // Outputs stay quiet in a reset cycle so an aborted access issues no write.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else begin
            mem_wait = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          case (op)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI: begin
              if (SUPPORT_ADDI != 0) begin
                state_d = S_ADDIEX;
              end else begin
                state_d   = S_ERROR;
                illegal_d = 1'b1;
              end
            end
            default: begin
              state_d   = S_ERROR;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          if (op == OP_LW)      state_d = S_MEMRD;
          else if (op == OP_SW) state_d = S_MEMWR;
          else                  state_d = S_ERROR;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
          else           mem_wait = 1'b1;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          retired    = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            retired = 1'b1;
            state_d = S_FETCH;
          end else begin
            mem_wait = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
          retired   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          retired       = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          retired   = 1'b1;
          state_d   = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          retired   = 1'b1;
          state_d   = S_FETCH;
        end
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_ERROR;
      endcase

      // A completed access already cleared the count via the default; only a
      // stalled access counts, and the bound is checked before incrementing.
      if (mem_wait) begin
        if (wait_cnt_q == WAIT_W'(MEM_WAIT_MAX)) begin
          state_d   = S_ERROR;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign illegal_op = illegal_q;
  assign bus_error  = bus_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven check of the multicycle MIPS controller.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retired;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op, bus_error;
  logic [3:0] state_dbg;

  logic       n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
  logic       n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_retired;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_source;
  logic       n_illegal_op, n_bus_error;
  logic [3:0] n_state_dbg;

  always #5 clk = ~clk;

  mc_control_fsm #(.SUPPORT_ADDI(1), .MEM_WAIT_MAX(15), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retired(retired), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  mc_control_fsm #(.SUPPORT_ADDI(0), .MEM_WAIT_MAX(15), .WAIT_W(8)) dut_noaddi (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .mem_to_reg(n_mem_to_reg), .reg_dst(n_reg_dst), .reg_write(n_reg_write),
    .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .pc_source(n_pc_source), .retired(n_retired), .illegal_op(n_illegal_op),
    .bus_error(n_bus_error), .state_dbg(n_state_dbg)
  );

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], retired}
  localparam logic [16:0] C_OFF      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FET_RDY  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FET_WAIT = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC      = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_MADR     = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MRD      = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB      = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_1;
  localparam logic [16:0] C_MWR_WAIT = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWR_RDY  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] C_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_AWB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_1;
  localparam logic [16:0] C_BR       = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_1;
  localparam logic [16:0] C_JMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_1;
  localparam logic [16:0] C_IWB      = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
    logic        bus;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  logic [16:0] act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, retired};

  task automatic add(input logic r, input logic [5:0] o, input logic rd,
                     input logic [3:0] s, input logic [16:0] c,
                     input logic il, input logic bu);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = rd; v.st = s; v.ctl = c; v.ill = il; v.bus = bu;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int rcount;

  initial begin
    rst = 1'b1; op = RT; mem_ready = 1'b1;
    tick();

    // second reset cycle: state already FETCH, all strobes gated off
    add(1, RT, 1, 0, C_OFF, 0, 0);
    // R-type
    add(0, RT, 1, 0, C_FET_RDY, 0, 0);
    add(0, RT, 1, 1, C_DEC, 0, 0);
    add(0, RT, 1, 6, C_EXEC, 0, 0);
    add(0, RT, 1, 7, C_AWB, 0, 0);
    // lw with three MEMRD wait cycles
    add(0, LW, 1, 0, C_FET_RDY, 0, 0);
    add(0, LW, 1, 1, C_DEC, 0, 0);
    add(0, LW, 1, 2, C_MADR, 0, 0);
    for (int i = 0; i < 3; i++) add(0, LW, 0, 3, C_MRD, 0, 0);
    add(0, LW, 1, 3, C_MRD, 0, 0);
    add(0, LW, 1, 4, C_MWB, 0, 0);
    // sw with two MEMWR wait cycles
    add(0, SW, 1, 0, C_FET_RDY, 0, 0);
    add(0, SW, 1, 1, C_DEC, 0, 0);
    add(0, SW, 1, 2, C_MADR, 0, 0);
    add(0, SW, 0, 5, C_MWR_WAIT, 0, 0);
    add(0, SW, 0, 5, C_MWR_WAIT, 0, 0);
    add(0, SW, 1, 5, C_MWR_RDY, 0, 0);
    // beq, j, addi
    add(0, BEQ, 1, 0, C_FET_RDY, 0, 0);
    add(0, BEQ, 1, 1, C_DEC, 0, 0);
    add(0, BEQ, 1, 8, C_BR, 0, 0);
    add(0, JMP, 1, 0, C_FET_RDY, 0, 0);
    add(0, JMP, 1, 1, C_DEC, 0, 0);
    add(0, JMP, 1, 9, C_JMP, 0, 0);
    add(0, ADI, 1, 0, C_FET_RDY, 0, 0);
    add(0, ADI, 1, 1, C_DEC, 0, 0);
    add(0, ADI, 1, 10, C_MADR, 0, 0);
    add(0, ADI, 1, 11, C_IWB, 0, 0);
    // 15 waits then ready at the limit: ready wins, no bus error
    for (int i = 0; i < 15; i++) add(0, JMP, 0, 0, C_FET_WAIT, 0, 0);
    add(0, JMP, 1, 0, C_FET_RDY, 0, 0);
    add(0, JMP, 1, 1, C_DEC, 0, 0);
    add(0, JMP, 1, 9, C_JMP, 0, 0);
    // illegal opcode trap, held until reset
    add(0, BAD, 1, 0, C_FET_RDY, 0, 0);
    add(0, BAD, 1, 1, C_DEC, 0, 0);
    add(0, BAD, 1, 15, C_OFF, 1, 0);
    add(0, RT, 0, 15, C_OFF, 1, 0);
    add(1, RT, 1, 15, C_OFF, 1, 0);
    // 16 stalled FETCH cycles -> bus error
    for (int i = 0; i < 16; i++) add(0, RT, 0, 0, C_FET_WAIT, 0, 0);
    add(0, RT, 0, 15, C_OFF, 0, 1);
    add(0, RT, 1, 15, C_OFF, 0, 1);
    add(1, RT, 1, 15, C_OFF, 0, 1);
    // reset during a MEMWR wait
    add(0, SW, 1, 0, C_FET_RDY, 0, 0);
    add(0, SW, 1, 1, C_DEC, 0, 0);
    add(0, SW, 1, 2, C_MADR, 0, 0);
    add(0, SW, 0, 5, C_MWR_WAIT, 0, 0);
    add(1, SW, 0, 5, C_OFF, 0, 0);
    add(0, SW, 1, 0, C_FET_RDY, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; op = vecs[i].op; mem_ready = vecs[i].rdy;
      @(negedge clk);
      chk("state", i, {28'd0, state_dbg}, {28'd0, vecs[i].st});
      chk("ctl", i, {15'd0, act_ctl}, {15'd0, vecs[i].ctl});
      chk("flags", i, {30'd0, illegal_op, bus_error}, {30'd0, vecs[i].ill, vecs[i].bus});
      tick();
    end

    // back-to-back R-type: one retire pulse every 4 cycles
    rst = 1'b1; op = RT; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    rcount = 0;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] pat [4];
      pat[0] = 4'd0; pat[1] = 4'd1; pat[2] = 4'd6; pat[3] = 4'd7;
      @(negedge clk);
      chk("rtype_seq_state", i, {28'd0, state_dbg}, {28'd0, pat[i % 4]});
      if (retired) rcount++;
      tick();
    end
    chk("rtype_retire_count", 0, rcount, 3);

    // addi with SUPPORT_ADDI=0 traps as illegal; with 1 it executes
    rst = 1'b1; op = ADI; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("noaddi_state", 0, {28'd0, n_state_dbg}, 32'd15);
    chk("noaddi_illegal", 0, {31'd0, n_illegal_op}, 32'd1);
    chk("noaddi_retired", 0, {31'd0, n_retired}, 32'd0);
    chk("addi_state", 0, {28'd0, state_dbg}, 32'd10);
    chk("addi_illegal", 0, {31'd0, illegal_op}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
